eth_tx_framer: RTL

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_tx_framer_if.sv | 21 ++
 rtl/eth_tx_framer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer_if.sv
// Upstream byte stream (valid/ready) plus the GMII transmit side of eth_tx_framer;
// master = traffic source/sink side, slave = the framer itself.
interface eth_tx_framer_if;
  logic [7:0] txData;
  logic       txDataValid;
  logic       txDataLast;
  logic       txReady;
  logic [7:0] gmiiTxData;
  logic       gmiiTxEn;
  logic       gmiiTxErr;

  modport master (
    output txData, txDataValid, txDataLast,
    input  txReady, gmiiTxData, gmiiTxEn, gmiiTxErr
  );

  modport slave (
    input  txData, txDataValid, txDataLast,
    output txReady, gmiiTxData, gmiiTxEn, gmiiTxErr
  );
endinterface

// File: rtl/eth_tx_framer.sv
// GMII Ethernet TX framer: preamble/SFD, payload, zero pad and optional CRC-32 FCS (ETH_TX_FCS_EN); all outputs
// registered, accepted byte on GMII one cycle later; txReady only in SFD/DATA, an underrun aborts with one gmiiTxErr cycle.
module eth_tx_framer #(
  parameter int IPG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic             txClk,
  input  logic             rst,
  eth_tx_framer_if.slave   tx_if
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IPG} state_t;

  localparam int IPG_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [IPG_W-1:0] IPG_LAST = IPG_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
  localparam logic [IPG_W-1:0] IPG_ONE  = IPG_W'(1);
  localparam logic [10:0]      MIN_CNT  = 11'(MIN_PAYLOAD);

`ifdef ETH_TX_FCS_EN
  localparam state_t BODY_NEXT = FCS;
`else
  localparam state_t BODY_NEXT = IPG;
`endif

  state_t             state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_en_q, tx_en_d;
  logic               tx_err_q, tx_err_d;
  logic               tx_ready_q, tx_ready_d;
  logic [2:0]         pre_cnt_q, pre_cnt_d;
  logic [10:0]        byte_cnt_q, byte_cnt_d;
  logic [IPG_W-1:0]   ipg_cnt_q, ipg_cnt_d;
`ifdef ETH_TX_FCS_EN
  logic [31:0]        crc_q, crc_d;
  logic [1:0]         fcs_idx_q, fcs_idx_d;
  logic [31:0]        fcs_val;

  // Reflected CRC-32 (0x04C11DB7 bit-reversed), one byte LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs_val = ~crc_q;
`endif

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    tx_data_d  = 8'h00;
    tx_en_d    = 1'b0;
    tx_err_d   = 1'b0;
    tx_ready_d = 1'b0;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ipg_cnt_d  = '0;
`ifdef ETH_TX_FCS_EN
    crc_d      = crc_q;
    fcs_idx_d  = fcs_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_if.txDataValid) begin
          state_d    = PREAMBLE;
          tx_data_d  = 8'h55;
          tx_en_d    = 1'b1;
          pre_cnt_d  = 3'd1;
          byte_cnt_d = '0;
`ifdef ETH_TX_FCS_EN
          crc_d      = 32'hFFFF_FFFF;
          fcs_idx_d  = '0;
`endif
        end
      end
      PREAMBLE: begin
        tx_en_d = 1'b1;
        // SFD goes out while DATA already accepts, so payload follows with no gap.
        if (pre_cnt_q == 3'd7) begin
          tx_data_d  = 8'hD5;
          tx_ready_d = 1'b1;
          state_d    = DATA;
        end else begin
          tx_data_d = 8'h55;
          pre_cnt_d = pre_cnt_q + 3'd1;
        end
      end
      DATA: begin
        tx_en_d = 1'b1;
        if (tx_if.txDataValid) begin
          tx_data_d  = tx_if.txData;
          byte_cnt_d = sat_inc(byte_cnt_q);
`ifdef ETH_TX_FCS_EN
          crc_d      = crc_byte(crc_q, tx_if.txData);
`endif
          if (tx_if.txDataLast) begin
            state_d = (byte_cnt_d < MIN_CNT) ? PAD : BODY_NEXT;
          end else begin
            tx_ready_d = 1'b1;
          end
        end else begin
          tx_err_d = 1'b1;
          state_d  = IPG;
        end
      end
      PAD: begin
        tx_en_d    = 1'b1;
        byte_cnt_d = sat_inc(byte_cnt_q);
`ifdef ETH_TX_FCS_EN
        crc_d      = crc_byte(crc_q, 8'h00);
`endif
        if (byte_cnt_d >= MIN_CNT) begin
          state_d = BODY_NEXT;
        end
      end
`ifdef ETH_TX_FCS_EN
      FCS: begin
        tx_en_d   = 1'b1;
        tx_data_d = fcs_val[8*fcs_idx_q +: 8];
        fcs_idx_d = fcs_idx_q + 2'd1;
        if (fcs_idx_q == 2'd3) begin
          state_d = IPG;
        end
      end
`endif
      IPG: begin
        // The first IPG cycle still shows the final frame byte; IDLE adds the last idle cycle.
        if (ipg_cnt_q == IPG_LAST) begin
          state_d = IDLE;
        end else begin
          ipg_cnt_d = ipg_cnt_q + IPG_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge txClk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_err_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ipg_cnt_q  <= '0;
`ifdef ETH_TX_FCS_EN
      crc_q      <= 32'hFFFF_FFFF;
      fcs_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      tx_err_q   <= tx_err_d;
      tx_ready_q <= tx_ready_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ipg_cnt_q  <= ipg_cnt_d;
`ifdef ETH_TX_FCS_EN
      crc_q      <= crc_d;
      fcs_idx_q  <= fcs_idx_d;
`endif
    end
  end

  assign tx_if.txReady    = tx_ready_q;
  assign tx_if.gmiiTxData = tx_data_q;
  assign tx_if.gmiiTxEn   = tx_en_q;
  assign tx_if.gmiiTxErr  = tx_err_q;

endmodule
